// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests words from instruction memory, holds them in IR
// and issues the decoded fields downstream once per instruction, honouring stall.
module instr_fetch (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  output logic        instr_valid,
  output logic [3:0]  opcode,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic [7:0]  pc,
  output logic        halt,
  output logic [15:0] retired
);

  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALTED
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] ir;
  logic        ir_load;
  logic        pc_inc;
  logic        issue;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        if (imem_ack) begin
          if (imem_rdata[15:12] == OP_HALT) begin
            state_nxt = HALTED;
          end else begin
            ir_load   = 1'b1;
            pc_inc    = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!stall) begin
          issue     = 1'b1;
          state_nxt = FETCH;
        end
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values,
  // so ordering between these statements cannot change behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= 8'h00;
      ir      <= 16'h0000;
      retired <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (ir_load) ir      <= imem_rdata;
      if (pc_inc)  pc      <= pc + 8'd1;
      if (issue)   retired <= retired + 16'd1;
    end
  end

  // Outputs are forced quiet while rst is held so the memory and decoder see
  // nothing even in the cycle before the registers clear.
  assign imem_req    = !rst && (state == FETCH);
  assign imem_addr   = rst ? 8'h00 : pc;
  assign instr_valid = !rst && issue;
  assign halt        = !rst && (state == HALTED);

  // Fields read as zero outside an issue cycle, which the decoder treats as a no-op.
  assign opcode = instr_valid ? ir[15:12] : 4'd0;
  assign rd     = instr_valid ? ir[11:8]  : 4'd0;
  assign rs     = instr_valid ? ir[7:4]   : 4'd0;
  assign rt     = instr_valid ? ir[3:0]   : 4'd0;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a memory model with wait states and a
// scoreboard of expected issued words, driven from a table of programs.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [3:0]  opcode, rd, rs, rt;
  logic [7:0]  pc;
  logic        halt;
  logic [15:0] retired;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .rd          (rd),
    .rs          (rs),
    .rt          (rt),
    .pc          (pc),
    .halt        (halt),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] mem [256];
  logic [15:0] sb [$];

  typedef struct packed {
    logic [0:3][15:0] prog;
    int               waits;
    int               stalls;
    bit               spurious;
    logic [7:0]       exp_pc;
    logic [15:0]      exp_retired;
  } case_t;

  case_t cases [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req"},   imem_req, 0);
    check({tag, "_addr"},  imem_addr, 0);
    check({tag, "_valid"}, instr_valid, 0);
    check({tag, "_flds"},  {opcode, rd, rs, rt}, 0);
    check({tag, "_halt"},  halt, 0);
  endtask

  // Holds rst for one edge with a tempting ack, then leaves the DUT in FETCH.
  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h1123; stall = 1'b0;
    @(posedge clk); #1;
    check_quiet("rst");
    check("rst_pc", pc, 0);
    check("rst_retired", retired, 0);
    rst = 1'b0; #1;
    check("idle_req", imem_req, 0);
    @(posedge clk); #1;
  endtask

  // Runs from FETCH until HALT has been held a few cycles or max_issue issued.
  task automatic run_case(input int waits, input int stalls, input bit spurious, input int max_issue);
    int         wcnt = 0;
    int         stall_left = 0;
    int         issued = 0;
    int         post_halt = 0;
    logic [7:0] exp_pc = 8'h00;
    bit         exp_issue = 1'b0;
    bit         exp_halt = 1'b0;
    bit         done = 1'b0;
    bit         in_fetch;
    logic [15:0] word;
    sb.delete();
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      stall = (stall_left > 0);
      if (stall) stall_left--;
      imem_ack = 1'b0; imem_rdata = 16'hFFFF;
      if (imem_req) begin
        if (wcnt == waits) begin
          imem_ack = 1'b1; imem_rdata = mem[imem_addr]; wcnt = 0;
        end else begin
          wcnt++;
        end
      end else if (spurious) begin
        imem_ack = 1'b1; imem_rdata = 16'hF0F0;
      end
      #1;
      in_fetch = !exp_issue && !exp_halt;
      check("imem_req", imem_req, in_fetch);
      check("imem_addr", imem_addr, exp_pc);
      check("pc", pc, exp_pc);
      check("halt", halt, exp_halt);
      if (exp_issue && !stall) begin
        check("instr_valid", instr_valid, 1);
        word = (sb.size() > 0) ? sb.pop_front() : 16'h0000;
        check("fields", {opcode, rd, rs, rt}, word);
        exp_issue = 1'b0;
        issued++;
      end else begin
        check("instr_valid", instr_valid, 0);
        check("fields_noop", {opcode, rd, rs, rt}, 0);
      end
      if (imem_ack && in_fetch) begin
        if (imem_rdata[15:12] == 4'hF) begin
          exp_halt = 1'b1;
        end else begin
          sb.push_back(imem_rdata);
          exp_pc++;
          exp_issue  = 1'b1;
          stall_left = stalls;
        end
      end
      if (exp_halt) post_halt++;
      done = (post_halt > 4) || (issued >= max_issue);
      @(posedge clk); #1;
    end
    stall = 1'b0; imem_ack = 1'b0;
    check("case_done", done, 1);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    cases[0] = '{prog: {16'h1123, 16'h7456, 16'hF000, 16'h0000}, waits: 0, stalls: 0,
                 spurious: 1'b0, exp_pc: 8'd2, exp_retired: 16'd2};
    cases[1] = '{prog: {16'h1123, 16'h7456, 16'hF000, 16'h0000}, waits: 3, stalls: 0,
                 spurious: 1'b0, exp_pc: 8'd2, exp_retired: 16'd2};
    cases[2] = '{prog: {16'h1123, 16'h7456, 16'hF000, 16'h0000}, waits: 0, stalls: 5,
                 spurious: 1'b1, exp_pc: 8'd2, exp_retired: 16'd2};
    cases[3] = '{prog: {16'h2ABC, 16'h3DEF, 16'h4012, 16'hF111}, waits: 1, stalls: 2,
                 spurious: 1'b1, exp_pc: 8'd3, exp_retired: 16'd3};

    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
      for (int i = 0; i < 4; i++) mem[i] = cases[c].prog[i];
      do_reset();
      run_case(cases[c].waits, cases[c].stalls, cases[c].spurious, 1000);
      check("final_pc", pc, cases[c].exp_pc);
      check("final_retired", retired, cases[c].exp_retired);
      check("final_halt", halt, 1);
      check("final_req", imem_req, 0);
    end

    // Reset while HALTED, then reset in FETCH with an ack pending.
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h1123; #1;
    check_quiet("rst_in_halt_now");
    @(posedge clk); #1;
    check_quiet("rst_from_halt");
    check("rst_from_halt_pc", pc, 0);
    check("rst_from_halt_retired", retired, 0);
    rst = 1'b0; imem_ack = 1'b0; #1;
    check("restart_idle_req", imem_req, 0);
    @(posedge clk); #1;
    check("restart_fetch_req", imem_req, 1);
    check("restart_fetch_addr", imem_addr, 0);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h1123; #1;
    check_quiet("rst_in_fetch_now");
    @(posedge clk); #1;
    rst = 1'b0; imem_ack = 1'b0; #1;
    check_quiet("rst_from_fetch");
    check("rst_from_fetch_pc", pc, 0);
    check("rst_from_fetch_retired", retired, 0);
    @(posedge clk); #1;
    run_case(0, 0, 1'b0, 1000);
    check("rerun_pc", pc, 3);
    check("rerun_retired", retired, 3);

    // pc wraps from 8'hFF to 8'h00 after 256 non-HALT fetches.
    for (int i = 0; i < 256; i++) mem[i] = 16'h2005 | (16'(i) << 4);
    do_reset();
    run_case(0, 0, 1'b0, 256);
    check("wrap_pc", pc, 8'h00);
    check("wrap_addr", imem_addr, 8'h00);
    check("wrap_req", imem_req, 1);
    check("wrap_retired", retired, 16'd256);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
